// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer.
// Optional overflow tracking is enabled with the MAC_SEQ_OVF_EN macro.
package mac_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    CAPTURE
  } state_e;

  // MAC command encodings driven on MAC_I
  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_ACC  = 2'b01;
  localparam logic [1:0] CMD_CLR  = 2'b10;

  // Full-precision product of one 2-bit operand pair (max 9)
  function automatic logic [3:0] pair_product(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Job, operand-stream and MAC-side signals of the operand sequencer.
// The ovf signal exists only when MAC_SEQ_OVF_EN is defined.
interface mac_operand_sequencer_if #(
  parameter int unsigned LEN_W = 4
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [1:0]       in_a;
  logic [1:0]       in_b;
  logic             in_ready;
  logic [1:0]       mac_a;
  logic [1:0]       mac_b;
  logic [1:0]       mac_i;
  logic             mac_s;
  logic [7:0]       mac_y;
  logic [7:0]       result;
  logic             done;
  logic             busy;

`ifdef MAC_SEQ_OVF_EN
  logic             ovf;

  modport master (
    output start, len, in_valid, in_a, in_b, mac_y,
    input  in_ready, mac_a, mac_b, mac_i, mac_s, result, done, busy, ovf
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, mac_y,
    output in_ready, mac_a, mac_b, mac_i, mac_s, result, done, busy, ovf
  );
`else
  modport master (
    output start, len, in_valid, in_a, in_b, mac_y,
    input  in_ready, mac_a, mac_b, mac_i, mac_s, result, done, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, mac_y,
    output in_ready, mac_a, mac_b, mac_i, mac_s, result, done, busy
  );
`endif

endinterface

// File: rtl/mac_seq_shadow_acc.sv
// Wide shadow accumulator that tracks the true dot-product sum so that
// wrap-around in the 8-bit MAC can be flagged. Used under MAC_SEQ_OVF_EN.
module mac_seq_shadow_acc
  import mac_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  output logic [8+LEN_W-1:0] sum
);

  localparam int unsigned SumW = 8 + LEN_W;

  logic [SumW-1:0] sum_q;

  // Clear at job start, add each accepted pair's product
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_q <= '0;
    end else if (acc_en) begin
      sum_q <= sum_q + SumW'(pair_product(a, b));
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mac_operand_sequencer.sv
// Upstream control stage for the 2-bit MAC: accepts a job (start + len),
// streams operand pairs over valid/ready, issues clear then one accumulate
// per pair, waits for the MAC to settle, captures Y and pulses done.
// Optional overflow flag: define MAC_SEQ_OVF_EN.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mac_operand_sequencer_if.slave bus
);

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic             in_ready_q;
  logic [1:0]       mac_a_q;
  logic [1:0]       mac_b_q;
  logic [1:0]       mac_i_q;
  logic             mac_s_q;
  logic [7:0]       result_q;
  logic             done_q;
  logic             busy_q;

  // in_ready_q is only ever high in RUN, so this is the RUN handshake
  logic accept;
  assign accept = bus.in_valid && in_ready_q;

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      in_ready_q  <= 1'b0;
      mac_a_q     <= 2'b00;
      mac_b_q     <= 2'b00;
      mac_i_q     <= CMD_HOLD;
      mac_s_q     <= 1'b0;
      result_q    <= 8'h00;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            remaining_q <= bus.len;
            mac_i_q     <= CMD_CLR;
            mac_s_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          // MAC clears on this edge; nothing can be accepted yet
          mac_i_q <= CMD_HOLD;
          if (remaining_q != '0) begin
            in_ready_q <= 1'b1;
            state_q    <= RUN;
          end else begin
            state_q <= DRAIN;
          end
        end
        RUN: begin
          if (accept) begin
            mac_a_q     <= bus.in_a;
            mac_b_q     <= bus.in_b;
            mac_i_q     <= CMD_ACC;
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end else begin
            mac_i_q <= CMD_HOLD;
          end
        end
        DRAIN: begin
          // Final accumulate lands on this edge; Y is valid in CAPTURE
          mac_i_q <= CMD_HOLD;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          result_q <= bus.mac_y;
          done_q   <= 1'b1;
          mac_s_q  <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mac_a    = mac_a_q;
  assign bus.mac_b    = mac_b_q;
  assign bus.mac_i    = mac_i_q;
  assign bus.mac_s    = mac_s_q;
  assign bus.result   = result_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

`ifdef MAC_SEQ_OVF_EN
  localparam int unsigned SumW = 8 + LEN_W;

  logic [SumW-1:0] shadow_sum;
  logic            ovf_q;

  mac_seq_shadow_acc #(
    .LEN_W (LEN_W)
  ) u_shadow_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == CLEAR),
    .acc_en ((state_q == RUN) && accept),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .sum    (shadow_sum)
  );

  // Overflow flag captured together with result and held with it
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == CAPTURE) begin
      ovf_q <= (shadow_sum > SumW'(255));
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed self-checking bench for mac_operand_sequencer, with a behavioural
// 2-bit MAC model per DUT. Overflow checks follow MAC_SEQ_OVF_EN.
module tb_mac_operand_sequencer;

  localparam int unsigned LW  = 4;
  localparam int unsigned LW5 = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mac_operand_sequencer_if #(.LEN_W(LW))  bus ();
  mac_operand_sequencer_if #(.LEN_W(LW5)) bus5 ();

  mac_operand_sequencer #(.LEN_W(LW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mac_operand_sequencer #(.LEN_W(LW5)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  // MAC models: not reset, start with stale contents
  logic [7:0] y4 = 8'hA5;
  logic [7:0] y5 = 8'h5A;

  always @(posedge clk) begin
    if (bus.mac_s) begin
      if (bus.mac_i == 2'b10) y4 <= 8'h00;
      else if (bus.mac_i == 2'b01) y4 <= y4 + ({6'd0, bus.mac_a} * {6'd0, bus.mac_b});
    end
    if (bus5.mac_s) begin
      if (bus5.mac_i == 2'b10) y5 <= 8'h00;
      else if (bus5.mac_i == 2'b01) y5 <= y5 + ({6'd0, bus5.mac_a} * {6'd0, bus5.mac_b});
    end
  end

  assign bus.mac_y  = y4;
  assign bus5.mac_y = y5;

  // Event monitors
  int done_cnt  = 0;
  int acc_cnt   = 0;
  int acc5_cnt  = 0;

  always @(posedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.in_valid && bus.in_ready) acc_cnt++;
    if (bus5.in_valid && bus5.in_ready) acc5_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done on one DUT; returns ticks spent
  task automatic wait_done(input string tag, input bit use5, input int bound, output int cycles);
    cycles = 0;
    while (((use5 ? bus5.done : bus.done) !== 1'b1) && cycles < bound) begin
      tick();
      cycles++;
    end
    chk(tag, use5 ? bus5.done : bus.done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] pa [4];
  logic [1:0] pb [4];
  logic [1:0] ga [3];
  logic [1:0] gb [3];
  int cyc;
  int a0;
  int dc;

  initial begin
    pa = '{2'd3, 2'd2, 2'd1, 2'd0};
    pb = '{2'd3, 2'd1, 2'd1, 2'd3};
    ga = '{2'd2, 2'd3, 2'd1};
    gb = '{2'd2, 2'd1, 2'd2};

    rst = 1'b1;
    bus.start = 1'b0;  bus.len = '0;  bus.in_valid = 1'b0;  bus.in_a = 2'd0;  bus.in_b = 2'd0;
    bus5.start = 1'b0; bus5.len = '0; bus5.in_valid = 1'b0; bus5.in_a = 2'd0; bus5.in_b = 2'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mac_i", bus.mac_i, 0);
    chk("rst_mac_s", bus.mac_s, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
`ifdef MAC_SEQ_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif

    // Test 1: LEN=4 back-to-back, expected sum 9+2+1+0=12
    bus.len = 4'd4;
    bus.start = 1'b1;
    tick();  // edge s
    bus.start = 1'b0;
    chk("t1_clr_cmd", bus.mac_i, 2);
    chk("t1_mac_s", bus.mac_s, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_clear_not_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_a = pa[0];
    bus.in_b = pb[0];
    tick();  // edge s+1, now RUN
    chk("t1_run_ready", bus.in_ready, 1);
    chk("t1_hold_after_clr", bus.mac_i, 0);
    for (int k = 0; k < 4; k++) begin
      bus.in_a = pa[k];
      bus.in_b = pb[k];
      tick();  // pair k+1 accepted at edge s+2+k
      chk("t1_acc_cmd", bus.mac_i, 1);
      chk("t1_mac_a", bus.mac_a, pa[k]);
      chk("t1_mac_b", bus.mac_b, pb[k]);
    end
    bus.in_valid = 1'b0;
    chk("t1_drain_not_ready", bus.in_ready, 0);
    chk("t1_no_early_done", bus.done, 0);
    tick();  // edge s+6, CAPTURE
    chk("t1_capture_hold", bus.mac_i, 0);
    chk("t1_capture_no_done", bus.done, 0);
    chk("t1_capture_busy", bus.busy, 1);
    tick();  // edge s+7 = s+N+3
    chk("t1_result", bus.result, 12);
    chk("t1_done", bus.done, 1);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_mac_s", bus.mac_s, 0);

    // Test 3: LEN=0 started in the DONE cycle; stray valid is ignored
    bus.len = 4'd0;
    bus.start = 1'b1;
    tick();  // edge s
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 2'd3;
    bus.in_b = 2'd3;
    chk("t1_done_pulse_width", bus.done, 0);
    chk("t1_done_count", done_cnt, 1);
    chk("t3_clr_cmd", bus.mac_i, 2);
    tick();  // edge s+1
    chk("t3_hold_cmd", bus.mac_i, 0);
    chk("t3_not_ready", bus.in_ready, 0);
    chk("t3_busy", bus.busy, 1);
    tick();  // edge s+2
    chk("t3_no_early_done", bus.done, 0);
    chk("t3_result_held", bus.result, 12);
    tick();  // edge s+3
    bus.in_valid = 1'b0;
    chk("t3_result", bus.result, 0);
    chk("t3_done", bus.done, 1);
    chk("t3_no_accepts", acc_cnt, 4);
    tick();
    chk("t3_done_count", done_cnt, 2);

    // Test 2: LEN=3 with two idle cycles between pairs, sum 4+3+2=9
    bus.len = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();  // RUN
    for (int k = 0; k < 3; k++) begin
      bus.in_a = ga[k];
      bus.in_b = gb[k];
      bus.in_valid = 1'b1;
      tick();
      chk("t2_acc_cmd", bus.mac_i, 1);
      chk("t2_mac_a", bus.mac_a, ga[k]);
      chk("t2_mac_b", bus.mac_b, gb[k]);
      bus.in_valid = 1'b0;
      bus.in_a = 2'd0;
      bus.in_b = 2'd0;
      if (k < 2) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          chk("t2_gap_hold", bus.mac_i, 0);
          chk("t2_gap_a_held", bus.mac_a, ga[k]);
          chk("t2_gap_ready", bus.in_ready, 1);
        end
      end
    end
    wait_done("t2_done", 1'b0, 6, cyc);
    chk("t2_done_latency", cyc, 2);
    chk("t2_result", bus.result, 9);
    tick();

    // Test 4: LEN=15, all (3,3) -> 135, no overflow
    a0 = acc_cnt;
    bus.len = 4'd15;
    bus.in_a = 2'd3;
    bus.in_b = 2'd3;
    bus.in_valid = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("t4_done", 1'b0, 30, cyc);
    bus.in_valid = 1'b0;
    chk("t4_done_latency", cyc, 18);
    chk("t4_result", bus.result, 135);
    chk("t4_accepts", acc_cnt - a0, 15);
`ifdef MAC_SEQ_OVF_EN
    chk("t4_ovf", bus.ovf, 0);
`endif
    tick();

    // Test 5: LEN_W=5, LEN=31, all (3,3) -> 279 mod 256 = 23
    bus5.len = 5'd31;
    bus5.in_a = 2'd3;
    bus5.in_b = 2'd3;
    bus5.in_valid = 1'b1;
    bus5.start = 1'b1;
    tick();
    bus5.start = 1'b0;
    wait_done("t5_done", 1'b1, 45, cyc);
    bus5.in_valid = 1'b0;
    chk("t5_done_latency", cyc, 34);
    chk("t5_result", bus5.result, 23);
    chk("t5_accepts", acc5_cnt, 31);
`ifdef MAC_SEQ_OVF_EN
    chk("t5_ovf", bus5.ovf, 1);
`endif
    tick();

    // Test 6: START while busy ignored, then reset mid-job
    bus.len = 4'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();  // RUN
    bus.in_valid = 1'b1;
    bus.in_a = 2'd1;
    bus.in_b = 2'd1;
    tick();
    bus.in_a = 2'd2;
    bus.in_b = 2'd2;
    tick();  // second pair accepted
    bus.in_valid = 1'b0;
    bus.len = 4'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t6_start_ignored", bus.mac_i, 0);
    chk("t6_still_busy", bus.busy, 1);
    chk("t6_still_ready", bus.in_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_ready", bus.in_ready, 0);
    chk("t6_rst_mac_a", bus.mac_a, 0);
    chk("t6_rst_mac_b", bus.mac_b, 0);
    chk("t6_rst_mac_i", bus.mac_i, 0);
    chk("t6_rst_mac_s", bus.mac_s, 0);
    chk("t6_rst_result", bus.result, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_rst_busy", bus.busy, 0);
`ifdef MAC_SEQ_OVF_EN
    chk("t6_rst_ovf", bus5.ovf, 0);
`endif
    dc = done_cnt;
    repeat (6) tick();
    chk("t6_no_done", done_cnt, dc);
    chk("t6_idle_after", bus.busy, 0);

    // Fresh job over stale MAC contents: (3,2),(2,2) -> 10
    bus.len = 4'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 2'd3;
    bus.in_b = 2'd2;
    tick();  // RUN, nothing accepted yet
    tick();
    chk("t6_fresh_acc1", bus.mac_i, 1);
    bus.in_a = 2'd2;
    bus.in_b = 2'd2;
    tick();
    chk("t6_fresh_acc2", bus.mac_a, 2);
    bus.in_valid = 1'b0;
    wait_done("t6_fresh_done", 1'b0, 6, cyc);
    chk("t6_fresh_latency", cyc, 2);
    chk("t6_fresh_result", bus.result, 10);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
